// File: rtl/fetch_prefetch_queue.sv
// Fetch-side prefetch buffer: streams sequential halfwords into a small FIFO and
// presents assembled 16/32-bit instructions with their PC; branch redirects flush.
module fetch_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump,
    input  logic [31:0] target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [15:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        extend
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);
    localparam logic [AW:0] TWO_C   = (AW+1)'(2);

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] hw;
    } entry_t;

    entry_t          fifo_q [DEPTH];
    entry_t          head0;
    logic [15:0]     head1_hw;
    logic [AW:0]     count_q, count_d, occ, pop_n;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [31:0]     fetch_addr_q, fetch_addr_d;
    logic [31:0]     inflight_addr_q, inflight_addr_d;
    logic            inflight_q, inflight_d;
    logic            inflight_epoch_q, inflight_epoch_d;
    logic            epoch_q, epoch_d;
    logic            head_ext, push, pop;

    always_comb begin
        head0     = fifo_q[rd_ptr_q];
        head1_hw  = fifo_q[rd_ptr_q + AW'(1)].hw;
        head_ext  = head0.hw[15];
        // Occupancy counts the in-flight read so its return always has a free slot.
        occ       = count_q + {{AW{1'b0}}, inflight_q};
        mem_req   = !rst && !jump && (occ < DEPTH_C);
        mem_addr  = fetch_addr_q;
        out_valid = !rst && !jump && (head_ext ? (count_q >= TWO_C) : (count_q >= ONE_C));
        extend    = out_valid && head_ext;
        instr     = '0;
        pc        = '0;
        if (out_valid) begin
            instr = {head0.hw, head_ext ? head1_hw : 16'h0000};
            pc    = head0.addr;
        end
        push  = inflight_q && !jump && (inflight_epoch_q == epoch_q);
        pop   = out_valid && out_ready;
        pop_n = pop ? (head_ext ? TWO_C : ONE_C) : '0;
    end

    always_comb begin
        count_d          = count_q;
        rd_ptr_d         = rd_ptr_q;
        wr_ptr_d         = wr_ptr_q;
        fetch_addr_d     = fetch_addr_q;
        inflight_d       = 1'b0;
        inflight_addr_d  = inflight_addr_q;
        inflight_epoch_d = inflight_epoch_q;
        epoch_d          = epoch_q;
        if (jump) begin
            count_d      = '0;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            fetch_addr_d = target;
            epoch_d      = !epoch_q;
        end else begin
            fetch_addr_d     = fetch_addr_q + {31'd0, mem_req};
            inflight_d       = mem_req;
            inflight_addr_d  = fetch_addr_q;
            inflight_epoch_d = epoch_q;
            wr_ptr_d         = wr_ptr_q + {{(AW-1){1'b0}}, push};
            rd_ptr_d         = rd_ptr_q + pop_n[AW-1:0];
            count_d          = count_q + {{AW{1'b0}}, push} - pop_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q          <= '0;
            rd_ptr_q         <= '0;
            wr_ptr_q         <= '0;
            fetch_addr_q     <= RESET_PC;
            inflight_q       <= 1'b0;
            inflight_addr_q  <= '0;
            inflight_epoch_q <= 1'b0;
            epoch_q          <= 1'b0;
        end else begin
            count_q          <= count_d;
            rd_ptr_q         <= rd_ptr_d;
            wr_ptr_q         <= wr_ptr_d;
            fetch_addr_q     <= fetch_addr_d;
            inflight_q       <= inflight_d;
            inflight_addr_q  <= inflight_addr_d;
            inflight_epoch_q <= inflight_epoch_d;
            epoch_q          <= epoch_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{addr: inflight_addr_q, hw: mem_rdata};
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: directed vector table, corner-case sequences and
// random redirect/stall traffic checked against an instruction-stream reference model.
module tb_fetch_prefetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, jump, out_ready;
    logic [31:0] target;
    logic        mem_req, out_valid, extend;
    logic [31:0] mem_addr, instr, pc;
    logic [15:0] mem_rdata = 16'hDEAD;

    fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .jump(jump), .target(target),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .instr(instr), .pc(pc), .extend(extend)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Program image: default hw[a] = 0x0100 + a, with per-address overrides.
    logic [15:0] ovr [logic [31:0]];

    function automatic logic [15:0] mem_hw(input logic [31:0] a);
        if (ovr.exists(a)) return ovr[a];
        return 16'h0100 + a[15:0];
    endfunction

    always @(posedge clk) mem_rdata <= mem_req ? mem_hw(mem_addr) : 16'hDEAD;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: halfwords requested/consumed since the last flush, next
    // fetch address, and the PC of the next instruction in program order.
    int unsigned issued, consumed;
    bit          m_inflight;
    logic [31:0] m_fetch, m_pc;

    // Snapshot of the latest sampled cycle, used by directed checks.
    bit          sv_valid, sv_req, acc_seen;
    logic [31:0] sv_pc, sv_addr, sv_instr, acc_pc, acc_instr;
    bit          acc_ext;

    task automatic model_reset();
        issued = 0; consumed = 0; m_inflight = 0;
        m_fetch = RESET_PC; m_pc = RESET_PC;
    endtask

    task automatic do_reset();
        rst = 1'b1; jump = 1'b0; target = '0; out_ready = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, RESET_PC);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One clock: drive inputs, compare at negedge, advance the model at posedge.
    task automatic cycle(input bit j, input logic [31:0] t, input bit r);
        int unsigned need, avail;
        bit          exp_req, exp_valid, acc;
        logic [15:0] h0, h1;
        jump = j; target = t; out_ready = r;
        acc_seen = 0;
        @(negedge clk);
        h0        = mem_hw(m_pc);
        h1        = mem_hw(m_pc + 32'd1);
        need      = h0[15] ? 2 : 1;
        avail     = issued - consumed - (m_inflight ? 1 : 0);
        exp_req   = !j && ((issued - consumed) < DEPTH);
        exp_valid = !j && (avail >= need);
        sv_valid = out_valid; sv_req = mem_req; sv_pc = pc; sv_addr = mem_addr; sv_instr = instr;
        chk("mem_req", mem_req, exp_req);
        if (exp_req) chk("mem_addr", mem_addr, m_fetch);
        chk("out_valid", out_valid, exp_valid);
        acc = exp_valid && r;
        if (acc && out_valid) begin
            chk("pc", pc, m_pc);
            chk("instr", instr, {h0, (need == 2) ? h1 : 16'h0000});
            chk("extend", extend, h0[15]);
            acc_seen = 1; acc_pc = pc; acc_instr = instr; acc_ext = extend;
        end
        @(posedge clk);
        if (j) begin
            issued = 0; consumed = 0; m_inflight = 0;
            m_fetch = t; m_pc = t;
        end else begin
            if (acc) begin
                consumed += need;
                m_pc += need;
            end
            m_inflight = exp_req;
            if (exp_req) begin
                issued++;
                m_fetch++;
            end
        end
        #1;
    endtask

    typedef struct {
        bit          j;
        logic [31:0] t;
        bit          r;
        bit          ev;
        logic [31:0] epc;
        bit          ereq;
        logic [31:0] eaddr;
    } vec_t;

    vec_t        vecs [6];
    int unsigned reqcnt;
    bit          found, after_chk, saw_bad;

    initial begin
        model_reset();

        // Streaming after reset, all short instructions.
        vecs[0] = '{0, 0, 1, 0, 32'h0, 1, 32'h0};
        vecs[1] = '{0, 0, 1, 0, 32'h0, 1, 32'h1};
        vecs[2] = '{0, 0, 1, 1, 32'h0, 1, 32'h2};
        vecs[3] = '{0, 0, 1, 1, 32'h1, 1, 32'h3};
        vecs[4] = '{0, 0, 1, 1, 32'h2, 1, 32'h4};
        vecs[5] = '{0, 0, 1, 1, 32'h3, 1, 32'h5};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(vecs[i].j, vecs[i].t, vecs[i].r);
            chk("t1_valid", sv_valid, vecs[i].ev);
            chk("t1_req", sv_req, vecs[i].ereq);
            if (vecs[i].ereq) chk("t1_addr", sv_addr, vecs[i].eaddr);
            if (vecs[i].ev) begin
                chk("t1_pc", sv_pc, vecs[i].epc);
                chk("t1_instr_hi", sv_instr[31:16], 16'h0100 + vecs[i].epc[15:0]);
            end
        end

        // Stalled consumer: exactly DEPTH requests, then drain back-to-back.
        do_reset();
        reqcnt = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 0);
            reqcnt += sv_req;
        end
        chk("t2_reqcnt", reqcnt, DEPTH);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1);
            chk("t2_valid", sv_valid, 1);
            chk("t2_pc", sv_pc, i);
            if (i == 0) chk("t2_req_nocredit", sv_req, 0);
            if (i == 1) begin
                chk("t2_resume_req", sv_req, 1);
                chk("t2_resume_addr", sv_addr, 32'h4);
            end
        end

        // Extended instruction at pc 2.
        ovr[32'h2] = 16'h8123;
        ovr[32'h3] = 16'h4567;
        do_reset();
        found = 0; after_chk = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(0, 0, 1);
            if (acc_seen) begin
                if (acc_pc == 32'h2) begin
                    chk("t3_instr", acc_instr, 32'h8123_4567);
                    chk("t3_extend", acc_ext, 1);
                    found = 1;
                end else if (found && !after_chk) begin
                    chk("t3_next_pc", acc_pc, 32'h4);
                    after_chk = 1;
                end
            end
        end
        chk("t3_seen", found, 1);

        // Extended head at pc 3 waits for its second halfword.
        ovr.delete();
        ovr[32'h3] = 16'h8ABC;
        ovr[32'h4] = 16'h1234;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cycle(0, 0, 1);
            if (i == 5) chk("t4_partial_wait", sv_valid, 0);
            if (i == 6) begin
                chk("t4_valid", sv_valid, 1);
                chk("t4_pc", sv_pc, 32'h3);
                chk("t4_instr", sv_instr, 32'h8ABC_1234);
            end
            if (i == 7) chk("t4_next_pc", sv_pc, 32'h5);
        end

        // Redirect while full with a read in flight.
        ovr.delete();
        do_reset();
        for (int i = 0; i < 4; i++) cycle(0, 0, 0);
        cycle(1, 32'h40, 0);
        chk("t5_jump_req", sv_req, 0);
        chk("t5_jump_valid", sv_valid, 0);
        cycle(0, 0, 1);
        chk("t5_req", sv_req, 1);
        chk("t5_addr", sv_addr, 32'h40);
        found = 0; saw_bad = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 1);
            if (acc_seen) begin
                if (!found) chk("t5_first_pc", acc_pc, 32'h40);
                found = 1;
                if (acc_pc < 32'h40) saw_bad = 1;
            end
        end
        chk("t5_seen", found, 1);
        chk("t5_no_stale", saw_bad, 0);

        // Reset mid-stream with a read in flight.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(0, 0, 1);
        do_reset();
        found = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 1);
            if (acc_seen && !found) begin
                chk("t6_first_pc", acc_pc, RESET_PC);
                found = 1;
            end
        end
        chk("t6_seen", found, 1);

        // Random stalls and redirects, including fetch-address wrap.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            bit j, r;
            r = ($urandom_range(0, 3) != 0);
            j = ($urandom_range(0, 15) == 0);
            t = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
            cycle(j, t, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
